// File: rtl/muxn_arb.sv
// muxn_arb: N-channel, W-bit stream multiplexer with valid/ready handshakes.
// Supports a fixed software select and round-robin arbitration. The output
// stage is a single-entry register that can drain and reload in one cycle.
module muxn_arb #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int SW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  din,
  input  logic [NCH-1:0]    din_valid,
  output logic [NCH-1:0]    din_ready,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  output logic [W-1:0]      dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [SW-1:0]     dout_ch
);

  logic [W-1:0]   dout_q, dout_d;
  logic           dout_valid_q, dout_valid_d;
  logic [SW-1:0]  dout_ch_q, dout_ch_d;
  logic [SW-1:0]  last_grant_q, last_grant_d;

  logic           grant_valid_s;
  logic [SW-1:0]  grant_s;
  logic [W-1:0]   sel_data_s;
  logic           load_en_s;
  logic           xfer_s;
  logic [NCH-1:0] din_ready_s;

  // Grant selection: fixed channel in mode 0, rotating priority after
  // last_grant in mode 1. The second round-robin pass handles the wrap:
  // it only hits when nothing above last_grant is requesting, so the lowest
  // valid index is the next one in rotation order.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_s       = {SW{1'b0}};
    if (mode == 1'b0) begin
      for (int i = 0; i < NCH; i++) begin
        if (!grant_valid_s && din_valid[i] && (sel == SW'(i))) begin
          grant_valid_s = 1'b1;
          grant_s       = SW'(i);
        end else begin
          grant_valid_s = grant_valid_s;
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!grant_valid_s && din_valid[i] && (SW'(i) > last_grant_q)) begin
          grant_valid_s = 1'b1;
          grant_s       = SW'(i);
        end else begin
          grant_valid_s = grant_valid_s;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (!grant_valid_s && din_valid[i]) begin
          grant_valid_s = 1'b1;
          grant_s       = SW'(i);
        end else begin
          grant_valid_s = grant_valid_s;
        end
      end
    end
  end

  // Data mux for the granted channel, plus per-channel accept. Accepts are
  // gated with rst_n so nothing is handshaked while reset is held.
  always_comb begin
    sel_data_s  = {W{1'b0}};
    load_en_s   = ~dout_valid_q | dout_ready;
    xfer_s      = load_en_s & grant_valid_s;
    din_ready_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (grant_s == SW'(i)) begin
        sel_data_s = din[i*W +: W];
      end else begin
        sel_data_s = sel_data_s;
      end
      din_ready_s[i] = rst_n & xfer_s & (grant_s == SW'(i));
    end
  end

  // Next state of the output register and the round-robin pointer.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_ch_d    = dout_ch_q;
    last_grant_d = last_grant_q;
    if (xfer_s) begin
      dout_d       = sel_data_s;
      dout_ch_d    = grant_s;
      dout_valid_d = 1'b1;
      if (mode == 1'b1) begin
        last_grant_d = grant_s;
      end else begin
        last_grant_d = last_grant_q;
      end
    end else if (load_en_s) begin
      dout_valid_d = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end
  end

  // State registers; reset leaves channel 0 with first round-robin priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= {W{1'b0}};
      dout_valid_q <= 1'b0;
      dout_ch_q    <= {SW{1'b0}};
      last_grant_q <= SW'(NCH - 1);
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_ch_q    <= dout_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign din_ready  = din_ready_s;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_ch    = dout_ch_q;

endmodule

// File: doc/muxn_arb.md
Name: muxn_arb

Overview:
- Parametrised N-channel, W-bit multiplexer.
- Generalises the 1-bit 4:1 mux in three ways: configurable channel count and width, per-channel valid/ready handshake, and a registered output stage.
- Two modes: fixed select (software-chosen channel) and round-robin arbitration across requesting channels.
- Sits between several producer streams and a single consumer; one beat per cycle maximum throughput.

Parameters:
- NCH, 4, number of input channels (2..16).
- W, 8, data width per channel in bits.
- SW, $clog2(NCH), width of the select and channel-index fields (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  NCH*W  packed channel data; channel i occupies bits [i*W +: W].
- din_valid  input  NCH  per-channel request; data on din is valid.
- din_ready  output  NCH  per-channel accept; a beat transfers when din_valid[i] & din_ready[i].
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SW  channel chosen in fixed mode.
- dout  output  W  registered selected data.
- dout_valid  output  1  output register holds a beat.
- dout_ready  input  1  consumer accept.
- dout_ch  output  SW  index of the channel that dout came from.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values (asynchronous, immediate): dout=0, dout_valid=0, dout_ch=0, last_grant=NCH-1, so channel 0 has first round-robin priority.
- Output stage: single-entry register.
  - load_en = !dout_valid | dout_ready.
  - Load when load_en and a grant exists: dout, dout_ch and dout_valid=1 update on the next edge. Latency is 1 cycle from accept to dout_valid.
  - If dout_valid & dout_ready and there is no grant, dout_valid drops to 0. dout and dout_ch hold their last values.
  - While dout_valid=1 and dout_ready=0, dout and dout_ch must stay stable.
- Grant, fixed mode (mode=0):
  - grant = sel when din_valid[sel]=1; otherwise no grant.
  - sel >= NCH (non-power-of-2 NCH) gives no grant.
  - last_grant is not updated.
- Grant, round-robin mode (mode=1):
  - Scan channels from last_grant+1 upward, wrapping NCH-1 -> 0.
  - The first channel with din_valid=1 is granted.
  - last_grant updates to the granted index only on an actual transfer.
- din_ready:
  - din_ready[i] = load_en & grant_valid & (grant==i). At most one bit is set; combinational from inputs and state.
  - din_ready must never assert for a channel whose din_valid=0.
- Back-to-back: with dout_ready held at 1 and requests present, one beat transfers every cycle; there are no bubbles.
- Simultaneous drain and load: the output register is overwritten with the new beat and dout_valid stays 1.
- Mode or sel change:
  - Takes effect in the same cycle's grant computation.
  - Never alters a beat already held in the output register.
  - Switching back to round-robin resumes from the stored last_grant.
- Reset mid-operation: the held beat is discarded, all din_ready outputs go low, and round-robin priority returns to channel 0.
- Producers may drop din_valid without a handshake; the block must not require valid to be held.

Test Plan:
- Reset then fixed mode, NCH=4, W=8: sel=2, din_valid=4'b0100, ch2 data 8'hA5, dout_ready=1 -> din_ready=4'b0100 that cycle; next cycle dout=8'hA5, dout_ch=2, dout_valid=1.
- Round-robin fairness: all four channels valid continuously with data 8'h10/8'h11/8'h12/8'h13, dout_ready=1 -> dout sequence 10,11,12,13,10,..., one beat per cycle, dout_ch 0,1,2,3,0.
- Backpressure: round-robin, ch1 and ch3 valid, dout_ready=0 for 3 cycles after the first load -> dout holds ch1 data, din_ready=0000 throughout; on release, the next beat comes from ch3.
- Fixed-mode idle select: sel=3, din_valid=4'b0001 -> no din_ready; dout_valid goes 0 after the current beat drains.
- Mode switch: run round-robin until last_grant=1, switch to fixed sel=0 for 2 beats, switch back -> the next round-robin grant is ch2 (if valid).
- Async reset mid-stream: assert rst_n low between edges while dout_valid=1 -> dout_valid=0, dout=0 immediately; after release with all channels valid, the first output is ch0.
